// File: rtl/uart_tx_fifo_if.sv
// Write-side bundle for uart_tx_fifo: byte strobe from the producer, FIFO status back.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 3
);
    logic              i_wr_en;
    logic [7:0]        i_wr_byte;
    logic              o_full;
    logic              o_empty;
    logic [ADDR_W:0]   o_count;
    logic              o_overflow;

    modport master (
        output i_wr_en, i_wr_byte,
        input  o_full, o_empty, o_count, o_overflow
    );

    modport slave (
        input  i_wr_en, i_wr_byte,
        output o_full, o_empty, o_count, o_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: a small circular FIFO feeding a
// START/DATA/STOP serializer that drains queued bytes back-to-back.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = 3,
    parameter int STOP_BITS    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_fifo_if.slave io_wr,
    output logic          o_dataline,
    output logic          o_busy,
    output logic          o_send_complete
);
    localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic              STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_idx;
    logic [BAUD_W-1:0]   r_baud;
    logic                r_stop_idx;
    logic                w_pop;
    logic                w_push;
    logic                w_baud_last;

    // Pop keys off the registered empty flag, so a byte written into an idle
    // FIFO starts its frame two edges after the write.
    assign w_pop       = (r_state == S_IDLE) && !r_empty;
    assign w_push      = io_wr.i_wr_en && ((r_count != COUNT_FULL) || w_pop);
    assign w_baud_last = (r_baud == BAUD_LAST);

    assign io_wr.o_full     = r_full;
    assign io_wr.o_empty    = r_empty;
    assign io_wr.o_count    = r_count;
    assign io_wr.o_overflow = r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (ADDR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (ADDR_W + 1)'(1);
            end
            r_full     <= (r_count == COUNT_FULL);
            r_empty    <= (r_count == '0);
            r_overflow <= io_wr.i_wr_en && !w_push;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_wr.i_wr_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_baud     <= '0;
            r_stop_idx <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_shift    <= r_mem[r_rd_ptr];
                r_bit_idx  <= '0;
                r_baud     <= '0;
                r_stop_idx <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_baud <= w_baud_last ? '0 : r_baud + BAUD_W'(1);
                if (w_baud_last && (r_state == S_DATA)) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
                if (w_baud_last && (r_state == S_STOP)) begin
                    r_stop_idx <= ~r_stop_idx;
                end
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        o_dataline      = 1'b1;
        o_busy          = 1'b1;
        o_send_complete = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (!r_empty) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                o_dataline = 1'b0;
                if (w_baud_last) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                o_dataline = r_shift[0];
                if (w_baud_last && (r_bit_idx == 3'd7)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_last && (r_stop_idx == STOP_LAST)) begin
                    o_send_complete = 1'b1;
                    w_state_next    = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a
// line monitor per instance decodes each frame and compares.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] line;
    logic [1:0] busy;
    logic [1:0] sc;
    int         checks   = 0;
    int         failures = 0;
    int         frames0  = 0;
    int         frames1  = 0;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         gapq [$];

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.ADDR_W(AW)) bus0 ();
    uart_tx_fifo_if #(.ADDR_W(AW)) bus1 ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .io_wr(bus0),
        .o_dataline(line[0]), .o_busy(busy[0]), .o_send_complete(sc[0])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .STOP_BITS(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .io_wr(bus1),
        .o_dataline(line[1]), .o_busy(busy[1]), .o_send_complete(sc[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void pop_exp(input int g, output bit ok, output logic [7:0] v);
        ok = 1'b0;
        v  = 8'h00;
        if (g == 0) begin
            if (q0.size() > 0) begin ok = 1'b1; v = q0.pop_front(); end
        end else begin
            if (q1.size() > 0) begin ok = 1'b1; v = q1.pop_front(); end
        end
    endfunction

    function automatic bit drained(input int g);
        if (g == 0) return (busy[0] == 1'b0) && (bus0.o_empty == 1'b1) && (q0.size() == 0);
        return (busy[1] == 1'b0) && (bus1.o_empty == 1'b1) && (q1.size() == 0);
    endfunction

    // Cycle-accurate receiver: cycle 1 is the first low sample of the start bit.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int FLEN = (10 + g) * CPB;
        initial begin
            int         idle_run;
            int         e_start, e_stop, e_busy, e_sc;
            bit         seen, aborted, ok;
            logic [7:0] rx, ev;
            idle_run = 0;
            seen     = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    seen     = 1'b0;
                    idle_run = 0;
                end else if (line[g] === 1'b1) begin
                    idle_run++;
                end else begin
                    if (g == 0 && seen) gapq.push_back(idle_run);
                    e_start = 0; e_stop = 0; e_busy = 0; e_sc = 0;
                    aborted = 1'b0;
                    rx      = '0;
                    for (int c = 1; c <= FLEN; c++) begin
                        if (c > 1) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (busy[g] !== 1'b1) e_busy++;
                        if (sc[g] !== (c == FLEN)) e_sc++;
                        if (c <= CPB) begin
                            if (line[g] !== 1'b0) e_start++;
                        end else if (c <= 9 * CPB) begin
                            if ((c - 1) % CPB == CPB / 2) rx = {line[g], rx[7:1]};
                        end else if (line[g] !== 1'b1) begin
                            e_stop++;
                        end
                    end
                    if (aborted) begin
                        seen     = 1'b0;
                        idle_run = 0;
                    end else begin
                        pop_exp(g, ok, ev);
                        chk($sformatf("rx_pending%0d", g), {31'd0, ok}, 32'd1);
                        if (ok) chk($sformatf("rx_byte%0d", g), {24'd0, rx}, {24'd0, ev});
                        chk($sformatf("start_low%0d", g), e_start, 0);
                        chk($sformatf("stop_high%0d", g), e_stop, 0);
                        chk($sformatf("busy_in_frame%0d", g), e_busy, 0);
                        chk($sformatf("send_complete_last%0d", g), e_sc, 0);
                        if (g == 0) frames0++; else frames1++;
                        @(negedge clk);
                        chk($sformatf("idle_after%0d", g), {29'd0, line[g], busy[g], sc[g]}, 32'd4);
                        seen     = 1'b1;
                        idle_run = 1;
                    end
                end
            end
        end
    end

    task automatic wait_busy(input int g, input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (busy[g] !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy[g]}, {31'd0, lvl});
    endtask

    task automatic wait_count(input logic [AW:0] val, input int budget, input string name);
        int n;
        n = 0;
        while (bus0.o_count !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {28'd0, bus0.o_count}, {28'd0, val});
    endtask

    task automatic wait_drain(input int g, input int budget, input string name);
        int n;
        n = 0;
        while (!drained(g) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, drained(g)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wr0_single(input logic [7:0] b);
        @(posedge clk); #1;
        bus0.i_wr_en   = 1'b1;
        bus0.i_wr_byte = b;
        q0.push_back(b);
        @(posedge clk); #1;
        bus0.i_wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2 [3];
        int         c2 [3];
        int         n, lows, f_before;

        bus0.i_wr_en = 1'b0; bus0.i_wr_byte = 8'h00;
        bus1.i_wr_en = 1'b0; bus1.i_wr_byte = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_line",     {31'd0, line[0]},         32'd1);
        chk("rst_busy",     {31'd0, busy[0]},         32'd0);
        chk("rst_sc",       {31'd0, sc[0]},           32'd0);
        chk("rst_overflow", {31'd0, bus0.o_overflow}, 32'd0);
        chk("rst_empty",    {31'd0, bus0.o_empty},    32'd1);
        chk("rst_full",     {31'd0, bus0.o_full},     32'd0);
        chk("rst_count",    {28'd0, bus0.o_count},    32'd0);
        chk("rst_line1",    {31'd0, line[1]},         32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single byte 0x31
        wr0_single(8'h31);
        @(negedge clk);
        chk("t1_count_wr",  {28'd0, bus0.o_count}, 32'd1);
        chk("t1_line_idle", {31'd0, line[0]},      32'd1);
        @(negedge clk);
        chk("t1_not_empty", {31'd0, bus0.o_empty}, 32'd0);
        @(negedge clk);
        chk("t1_count_pop", {28'd0, bus0.o_count}, 32'd0);
        chk("t1_line_start", {31'd0, line[0]},     32'd0);
        chk("t1_busy",      {31'd0, busy[0]},      32'd1);
        @(negedge clk);
        chk("t1_empty_pop", {31'd0, bus0.o_empty}, 32'd1);
        wait_drain(0, 200, "t1_drain");

        // Three consecutive writes
        gapq.delete();
        b2 = '{8'hA5, 8'h5A, 8'hFF};
        c2 = '{1, 2, 2};
        @(posedge clk); #1;
        bus0.i_wr_en = 1'b1; bus0.i_wr_byte = b2[0]; q0.push_back(b2[0]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) begin
                bus0.i_wr_byte = b2[i+1];
                q0.push_back(b2[i+1]);
            end else begin
                bus0.i_wr_en = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t2_count%0d", i), {28'd0, bus0.o_count}, c2[i]);
        end
        wait_count(4'd1, 200, "t2_count_dec1");
        wait_count(4'd0, 200, "t2_count_dec0");
        wait_drain(0, 300, "t2_drain");
        chk("t2_gap_n", gapq.size(), 3);
        if (gapq.size() == 3) begin
            chk("t2_gap1", gapq[1], 1);
            chk("t2_gap2", gapq[2], 1);
        end

        // Fill while a frame is in flight, then overflow
        wr0_single(8'h10);
        wait_busy(0, 1'b1, 20, "t3_busy");
        @(posedge clk); #1;
        bus0.i_wr_en = 1'b1; bus0.i_wr_byte = 8'h80; q0.push_back(8'h80);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i < 7) begin
                bus0.i_wr_byte = 8'h81 + 8'(i);
                q0.push_back(8'h81 + 8'(i));
            end else if (i == 7) begin
                bus0.i_wr_byte = 8'h99;
            end else begin
                bus0.i_wr_en = 1'b0;
            end
            @(negedge clk);
            if (i == 7) begin
                chk("t3_count8",   {28'd0, bus0.o_count},    32'd8);
                chk("t3_no_ovf",   {31'd0, bus0.o_overflow}, 32'd0);
            end
            if (i == 8) begin
                chk("t3_full",     {31'd0, bus0.o_full},     32'd1);
                chk("t3_count_ov", {28'd0, bus0.o_count},    32'd8);
                chk("t3_overflow", {31'd0, bus0.o_overflow}, 32'd1);
            end
        end
        @(negedge clk);
        chk("t3_ovf_pulse", {31'd0, bus0.o_overflow}, 32'd0);

        // Write in the same cycle the FSM pops a full FIFO
        wait_busy(0, 1'b0, 100, "t4_idle_slot");
        bus0.i_wr_en = 1'b1; bus0.i_wr_byte = 8'hC3; q0.push_back(8'hC3);
        @(negedge clk);
        bus0.i_wr_en = 1'b0;
        chk("t4_count",   {28'd0, bus0.o_count},    32'd8);
        chk("t4_no_ovf",  {31'd0, bus0.o_overflow}, 32'd0);
        chk("t4_popped",  {31'd0, busy[0]},         32'd1);
        wait_drain(0, 1000, "t4_drain");

        // Reset mid-DATA with three bytes queued
        @(posedge clk); #1;
        bus0.i_wr_en = 1'b1; bus0.i_wr_byte = 8'h11; q0.push_back(8'h11);
        @(posedge clk); #1;
        bus0.i_wr_byte = 8'h22; q0.push_back(8'h22);
        @(posedge clk); #1;
        bus0.i_wr_byte = 8'h33; q0.push_back(8'h33);
        @(posedge clk); #1;
        bus0.i_wr_en = 1'b0;
        wait_busy(0, 1'b1, 20, "t6_busy");
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        f_before = frames0;
        @(negedge clk);
        chk("t6_line",  {31'd0, line[0]},      32'd1);
        chk("t6_busy0", {31'd0, busy[0]},      32'd0);
        chk("t6_empty", {31'd0, bus0.o_empty}, 32'd1);
        chk("t6_count", {28'd0, bus0.o_count}, 32'd0);
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (line[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
        end
        chk("t6_line_quiet", lows, 0);
        chk("t6_no_frames", frames0, f_before);

        // Two stop bits on the second instance
        @(posedge clk); #1;
        bus1.i_wr_en = 1'b1; bus1.i_wr_byte = 8'h4E; q1.push_back(8'h4E);
        @(posedge clk); #1;
        bus1.i_wr_en = 1'b0;
        wait_busy(1, 1'b1, 20, "t5_busy");
        n = 0;
        while (busy[1] === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t5_frame_len", n, 44);
        wait_drain(1, 100, "t5_drain");
        chk("t5_frames", frames1, 1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
